// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_pkg
//  Description : Shared definitions for the parallel-in / serial-out
//                transmitter: FSM state encoding and the default word width.
//  Contents    : state_t     - IDLE / SHIFT
//                WIDTH_DEFAULT - default serialised word width
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx_if
//  Description : Handshake / serial bus of piso_tx.
//  Signals     : in_valid, in_data  - upstream word offer
//                in_ready           - transmitter can take a word
//                d_in, d_valid      - serial bit and its qualifier
//                frame              - marks the first bit of each word
//                busy               - shifter active or holding register full
//  Modports    : master - the environment (upstream source, serial sink)
//                slave  - the transmitter itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface piso_tx_if #(
    parameter int WIDTH = piso_pkg::WIDTH_DEFAULT
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             d_in;
    logic             d_valid;
    logic             frame;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, d_in, d_valid, frame, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, d_in, d_valid, frame, busy
    );
endinterface : piso_tx_if
`default_nettype wire

// File: rtl/piso_hold.sv
`default_nettype none
// ============================================================================
//  Module      : piso_hold
//  Description : One-word holding register with its occupancy flag. Lets the
//                transmitter accept the next word while the current one is
//                still being shifted out.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                wr_i      - capture data_i and mark full
//                data_i    - word to capture
//                rd_i      - held word consumed, mark empty
//                full_o    - a word is held
//                data_o    - the held word
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_hold
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             wr_i,
    input  wire [WIDTH-1:0] data_i,
    input  wire             rd_i,
    output logic            full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // A write is only issued while empty and a read only while full, so the
    // two never coincide; write still wins to keep the word safe if they did.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (wr_i) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (rd_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule : piso_hold
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx
//  Description : Parallel-in / serial-out transmitter. Accepts WIDTH-bit words
//                on a valid/ready handshake and emits them one bit per cycle,
//                MSB or LSB first, with a frame marker on the first bit. A
//                one-word holding register allows gap-free back-to-back words.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                bus      - piso_tx_if slave modport (handshake + serial out)
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire        clk,
    input  wire        rst,
    piso_tx_if.slave   bus
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic             d_in_q;
    logic             d_valid_q;
    logic             frame_q;
    logic             busy_q;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;

    logic             xfer;
    logic             last_bit;
    logic             load_hold;
    logic             load_new;
    logic             hold_wr;
    logic [WIDTH-1:0] shift_src;
    logic             shift_bit;
    logic [WIDTH-1:0] shift_rest;

    piso_hold #(
        .WIDTH  (WIDTH)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .wr_i   (hold_wr),
        .data_i (bus.in_data),
        .rd_i   (load_hold),
        .full_o (hold_full),
        .data_o (hold_data)
    );

    // Ready depends only on the registered occupancy flag.
    assign bus.in_ready = ~hold_full;

    always_comb begin
        xfer      = bus.in_valid & ~hold_full & ~rst;
        last_bit  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
        // The held word has priority at the end of a word; while it is held
        // in_ready is low, so no new transfer can compete with it.
        load_hold = last_bit & hold_full;
        // A new word goes straight to the shifter when idle or when it lands
        // exactly on the last bit of the current word.
        load_new  = xfer & ((state_q == IDLE) | last_bit);
        hold_wr   = xfer & (state_q == SHIFT) & ~last_bit;
        if (load_hold) begin
            shift_src = hold_data;
        end else if (load_new) begin
            shift_src = bus.in_data;
        end else begin
            shift_src = shreg_q;
        end
    end

    // shift_bit is the next bit to present, shift_rest what remains queued.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_bit  = shift_src[WIDTH-1];
            assign shift_rest = shift_src << 1;
        end else begin : g_lsb_first
            assign shift_bit  = shift_src[0];
            assign shift_rest = shift_src >> 1;
        end
    endgenerate

    // cnt_q is the index of the bit currently on d_in, so the cycle with
    // cnt_q == WIDTH-1 is the last bit of the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            d_in_q    <= 1'b0;
            d_valid_q <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else if (load_hold || load_new) begin
            state_q   <= SHIFT;
            cnt_q     <= '0;
            shreg_q   <= shift_rest;
            d_in_q    <= shift_bit;
            d_valid_q <= 1'b1;
            frame_q   <= 1'b1;
            busy_q    <= 1'b1;
        end else if ((state_q == SHIFT) && !last_bit) begin
            state_q   <= SHIFT;
            cnt_q     <= cnt_q + CW'(1);
            shreg_q   <= shift_rest;
            d_in_q    <= shift_bit;
            d_valid_q <= 1'b1;
            frame_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            // Idle, or last bit sent with nothing pending.
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            d_in_q    <= 1'b0;
            d_valid_q <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= hold_wr;
        end
    end

    assign bus.d_in    = d_in_q;
    assign bus.d_valid = d_valid_q;
    assign bus.frame   = frame_q;
    assign bus.busy    = busy_q;

endmodule : piso_tx
`default_nettype wire

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4: word width in bits, range 2..16.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream has a word on in_data.
REQ-007 in_data  input  WIDTH  parallel word to serialize.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 d_in  output  1  serial data bit; feeds the sipo serial input.
REQ-010 d_valid  output  1  d_in carries a valid bit this cycle.
REQ-011 frame  output  1  high only on the first bit of each word.
REQ-012 busy  output  1  shifter is active or the holding register is full.

Function
REQ-013 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; there is no other acceptance path.
REQ-014 in_ready SHALL equal NOT hold_full, driven from registered state only, with no combinational path from in_valid.
REQ-015 FSM states SHALL be IDLE and SHIFT. IDLE->SHIFT on a transfer. SHIFT->IDLE after the last bit when there is no pending word. SHIFT->SHIFT when a next word is available.
REQ-016 A transfer in IDLE SHALL load the shift register directly. The first bit SHALL appear in the following cycle with d_valid=1 and frame=1, so latency is 1 cycle.
REQ-017 Each word SHALL occupy exactly WIDTH consecutive d_valid cycles, in the order set by MSB_FIRST.
REQ-018 A bit counter of width clog2(WIDTH) SHALL count 0..WIDTH-1 and wrap to 0 on the last bit. It SHALL have no off-by-one at WIDTH = 2^n.
REQ-019 A transfer during SHIFT on a non-last bit SHALL write the one-word holding register and set hold_full.
REQ-020 Last-bit cycle with hold_full=1: the next edge SHALL move the held word into the shifter, clear hold_full, and produce frame=1 with no idle gap.
REQ-021 Last-bit cycle with hold_full=0 and a transfer in the same cycle: the new word SHALL load the shifter directly, bypassing the holding register, with no gap.
REQ-022 A held word followed by continuous in_valid SHALL give a sustained throughput of 1 bit per cycle with no dropped or duplicated word.
REQ-023 In IDLE, d_in=0, d_valid=0 and frame=0.
REQ-024 in_data SHALL be sampled only at the transfer edge. Later changes to in_data SHALL NOT affect the word in flight.

Reset
REQ-025 While rst=1 at an edge, the block SHALL set state=IDLE, counter=0, shifter=0 and hold_full=0.
REQ-026 Reset values: d_in=0, d_valid=0, frame=0, busy=0, in_ready=1 from the first cycle after reset.
REQ-027 rst during SHIFT SHALL abort the word and discard the held word. No partial bit SHALL follow the reset edge.
REQ-028 in_valid asserted in the same cycle as rst=1 SHALL NOT be accepted.

Structure
REQ-029 The shared package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and the WIDTH default constant.
REQ-030 The holding register plus hold_full SHALL be a single sub-module, piso_hold. Counter, FSM and shifter SHALL be in piso_tx.
REQ-031 All outputs SHALL be registered, with the exception of in_ready, which is derived from a register.

Verification
REQ-032 Scenario, single word: WIDTH=4, MSB_FIRST=1, send 4'b1101 once -> d_in=1,1,0,1 on 4 consecutive cycles starting 1 cycle after the transfer; frame only on the first; then IDLE.
REQ-033 Scenario, back-to-back: send 4'b1101 then 4'b0110 with in_valid held high -> 8 contiguous d_valid cycles, bits 1,1,0,1,0,1,1,0; frame on cycles 1 and 5.
REQ-034 Scenario, backpressure: 3 words with in_valid held high -> in_ready=0 while hold_full=1; all 12 bits arrive in order; no word lost.
REQ-035 Scenario, reset mid-frame: rst=1 at bit 2 of 4'b1010 while a word is held -> next cycle d_valid=0, busy=0, in_ready=1; a later 4'b0011 serializes cleanly.
REQ-036 Scenario, LSB-first: MSB_FIRST=0, send 4'b1000 -> d_in=0,0,0,1.
REQ-037 Scenario, end-to-end: connect d_in to the sipo serial input -> after 4 valid bits, the sipo parallel output equals the sent word.
